cache_mem_bridge: RTL and testbench
===================================

// Module: cache_mem_bridge
// PURPOSE
//  Memory-side responder for the data cache's miss/write-back interface. Latches the cache's
//  single-cycle write-back (mem_w_ena) and refill-read (mem_r_ena) requests, replays them to a
//  req/ack backing RAM port (write first, then read) and returns refill data with a one-cycle
//  axi_r_valid pulse. Sits between the cache and the RAM/bus; ack timeout guards against a hung RAM.
// PARAMETERS
//  ADDR_W   64   request/RAM address width
//  DATA_W   64   data width (one cache block = one word)
//  TIMEOUT  255  max cycles to wait for ram_ack before aborting an access (>=1)
// PORTS
//  clk          in   1       clock, all flops posedge
//  rst          in   1       asynchronous active-high reset
//  mem_w_ena    in   1       write-back request pulse from cache
//  mem_waddr    in   ADDR_W  write-back address
//  mem_wdata    in   DATA_W  write-back data
//  mem_r_ena    in   1       refill read request pulse from cache
//  mem_raddr    in   ADDR_W  refill address
//  axi_r_valid  out  1       refill data valid, exactly one cycle per accepted read
//  rdata        out  DATA_W  refill data, held until next response
//  busy         out  1       bridge has pending or in-flight work
//  req_drop     out  1       one-cycle pulse: request arrived while busy and was discarded
//  rd_err       out  1       one-cycle pulse alongside axi_r_valid when the read timed out
//  ram_req      out  1       RAM access request, held until ram_ack
//  ram_we       out  1       1 = write, 0 = read
//  ram_addr     out  ADDR_W  RAM address, bits [2:0] forced to 0
//  ram_wdata    out  DATA_W  RAM write data
//  ram_rdata    in   DATA_W  RAM read data, valid when ram_ack=1 on a read
//  ram_ack      in   1       RAM completion; may be high in same cycle as ram_req
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs, pending flags, holding regs, timeout counter = 0.
//  - Accept: in IDLE with busy=0, a cycle with mem_w_ena and/or mem_r_ena latches addr/data into
//    write and/or read holding regs and sets pending flags; both may be accepted in one cycle.
//  - busy = (state!=IDLE) | any pending flag. Requests seen while busy=1 are discarded; req_drop=1
//    the following cycle (one pulse per offending cycle).
//  - FSM: IDLE -> WRITE if write pending, else READ if read pending. WRITE -> READ if read pending
//    else IDLE. READ -> RESP. RESP -> IDLE. Transitions out of WRITE/READ occur on the edge where
//    ram_ack=1 or the timeout counter reaches TIMEOUT-1.
//  - WRITE: ram_req=1, ram_we=1, ram_addr={waddr[ADDR_W-1:3],3'b0}, ram_wdata=wdata; pending_w
//    clears on exit. Timeout on write: access abandoned silently, ordering kept (read still runs).
//  - READ: ram_req=1, ram_we=0, ram_addr={raddr[ADDR_W-1:3],3'b0}; on ack rdata<=ram_rdata;
//    on timeout rdata<=0 and rd_err flagged for RESP. pending_r clears on exit.
//  - RESP: axi_r_valid=1 for exactly one cycle (rd_err with it on timeout); ram_req=0.
//  - Timeout counter: cleared on entry to WRITE/READ, increments each cycle ram_req=1 without ack.
//  - ram_req/ram_we/ram_addr/ram_wdata are registered outputs, stable while ram_req=1.
//  - Latency (ack same cycle as req): read-only pulse at cycle 0 -> axi_r_valid in cycle 2;
//    write+read pulse -> RAM write in cycle 1, read in cycle 2, axi_r_valid in cycle 3.
//  - Write then read to same block returns the just-written data (RAM ordering guaranteed).
//  - Reset mid-access: ram_req drops immediately, no axi_r_valid is ever produced for the aborted
//    request; the cache reissues after reset.
// TESTING
//  - Read-only: mem_r_ena, raddr=0x1008, ack immediate, ram_rdata=0xAA -> axi_r_valid cycle 2, rdata=0xAA, ram_addr=0x1008.
//  - W+R same cycle: waddr=0x2000 wdata=0x55, raddr=0x3000 -> ram write 0x2000 then read 0x3000, one axi_r_valid cycle 3.
//  - Write-back then refill same block 0x40 wdata=0x1234 (RAM model) -> rdata=0x1234.
//  - ram_ack delayed 5 cycles on read -> ram_req/addr stable 6 cycles, axi_r_valid one cycle after ack, busy low next.
//  - TIMEOUT=4, ram_ack never -> after 4 READ cycles axi_r_valid=1, rd_err=1, rdata=0; mem_r_ena while busy -> req_drop=1.
//  - Assert rst during READ wait -> ram_req=0, busy=0 immediately, no axi_r_valid after release.

Source files
------------

// File: rtl/cache_mem_bridge.sv
// Cache miss/write-back responder: latches write/read pulses, replays them write-first on a req/ack RAM port.
// Read pulse -> RAM access next cycle -> refill pulse one cycle after ack; requests arriving while busy are dropped.
module cache_mem_bridge #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_w_ena,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_r_ena,
  input  logic [ADDR_W-1:0] mem_raddr,
  output logic              axi_r_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              req_drop,
  output logic              rd_err,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              pend_w_q, pend_w_d;
  logic              pend_r_q, pend_r_d;
  logic [ADDR_W-4:0] waddr_q, waddr_d;
  logic [ADDR_W-4:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              axi_r_valid_q, axi_r_valid_d;
  logic              rd_err_q, rd_err_d;
  logic              req_drop_q, req_drop_d;

  logic              busy_w;
  logic              accept;
  logic              tmo_hit;
  logic              access_done;
  logic              unused_addr_lsbs;

  // Block-aligned RAM addresses never use the byte offset.
  assign unused_addr_lsbs = ^{mem_waddr[2:0], mem_raddr[2:0]};

  assign busy_w      = (state_q != S_IDLE) | pend_w_q | pend_r_q;
  assign accept      = ~busy_w;
  assign tmo_hit     = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign access_done = ram_ack | tmo_hit;

  always_comb begin
    state_d       = state_q;
    pend_w_d      = pend_w_q;
    pend_r_d      = pend_r_q;
    waddr_d       = waddr_q;
    raddr_d       = raddr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rd_err_d      = 1'b0;
    req_drop_d    = busy_w & (mem_w_ena | mem_r_ena);

    if (accept) begin
      if (mem_w_ena) begin
        pend_w_d = 1'b1;
        waddr_d  = mem_waddr[ADDR_W-1:3];
        wdata_d  = mem_wdata;
      end
      if (mem_r_ena) begin
        pend_r_d = 1'b1;
        raddr_d  = mem_raddr[ADDR_W-1:3];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pend_w_d)      state_d = S_WRITE;
        else if (pend_r_d) state_d = S_READ;
      end
      S_WRITE: begin
        // A timed-out write is abandoned but the queued read still follows it.
        if (access_done) begin
          pend_w_d = 1'b0;
          state_d  = pend_r_q ? S_READ : S_IDLE;
        end
      end
      S_READ: begin
        if (access_done) begin
          pend_r_d = 1'b0;
          state_d  = S_RESP;
          rdata_d  = ram_ack ? ram_rdata : '0;
          rd_err_d = ~ram_ack;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM-side and response outputs are computed from the next state so they leave a flop directly.
  always_comb begin
    ram_req_d     = (state_d == S_WRITE) | (state_d == S_READ);
    ram_we_d      = (state_d == S_WRITE);
    ram_addr_d    = '0;
    ram_wdata_d   = '0;
    axi_r_valid_d = (state_d == S_RESP);
    if (state_d == S_WRITE) begin
      ram_addr_d  = {waddr_d, 3'b000};
      ram_wdata_d = wdata_d;
    end else if (state_d == S_READ) begin
      ram_addr_d  = {raddr_d, 3'b000};
    end

    if (ram_req_d) begin
      if (state_d != state_q) cnt_d = '0;
      else if (!ram_ack)      cnt_d = cnt_q + CNT_W'(1);
      else                    cnt_d = cnt_q;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pend_w_q      <= 1'b0;
      pend_r_q      <= 1'b0;
      waddr_q       <= '0;
      raddr_q       <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      cnt_q         <= '0;
      ram_req_q     <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      axi_r_valid_q <= 1'b0;
      rd_err_q      <= 1'b0;
      req_drop_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_w_q      <= pend_w_d;
      pend_r_q      <= pend_r_d;
      waddr_q       <= waddr_d;
      raddr_q       <= raddr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      cnt_q         <= cnt_d;
      ram_req_q     <= ram_req_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      axi_r_valid_q <= axi_r_valid_d;
      rd_err_q      <= rd_err_d;
      req_drop_q    <= req_drop_d;
    end
  end

  assign busy        = busy_w;
  assign axi_r_valid = axi_r_valid_q;
  assign rdata       = rdata_q;
  assign rd_err      = rd_err_q;
  assign req_drop    = req_drop_q;
  assign ram_req     = ram_req_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge: RAM model with programmable ack delay plus a refill scoreboard.
module tb_cache_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_w_ena = 1'b0;
  logic [63:0] mem_waddr = '0;
  logic [63:0] mem_wdata = '0;
  logic        mem_r_ena = 1'b0;
  logic [63:0] mem_raddr = '0;
  logic        axi_r_valid, busy, req_drop, rd_err, ram_req, ram_we, ram_ack;
  logic [63:0] rdata, ram_addr, ram_wdata, ram_rdata;

  // Second instance with a short timeout and a RAM that never acknowledges.
  logic        mem_r_ena_t = 1'b0;
  logic        mem_w_ena_t = 1'b0;
  logic        ram_ack_t = 1'b0;
  logic        axi_r_valid_t, busy_t, req_drop_t, rd_err_t, ram_req_t, ram_we_t;
  logic [63:0] rdata_t, ram_addr_t, ram_wdata_t;

  always #5 clk = ~clk;

  cache_mem_bridge #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .mem_w_ena(mem_w_ena), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_r_ena(mem_r_ena), .mem_raddr(mem_raddr),
    .axi_r_valid(axi_r_valid), .rdata(rdata), .busy(busy), .req_drop(req_drop), .rd_err(rd_err),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  cache_mem_bridge #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst),
    .mem_w_ena(mem_w_ena_t), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_r_ena(mem_r_ena_t), .mem_raddr(mem_raddr),
    .axi_r_valid(axi_r_valid_t), .rdata(rdata_t), .busy(busy_t), .req_drop(req_drop_t), .rd_err(rd_err_t),
    .ram_req(ram_req_t), .ram_we(ram_we_t), .ram_addr(ram_addr_t), .ram_wdata(ram_wdata_t),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack_t)
  );

  // RAM model
  logic [63:0] mem [0:8191];
  logic        pl_en = 1'b0;
  logic [12:0] pl_idx = '0;
  logic [63:0] pl_dat = '0;
  int          ack_delay = 0;
  logic        ack_never = 1'b0;
  int          wcnt;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_dat;
    else if (ram_req && ram_ack && ram_we) mem[ram_addr[15:3]] <= ram_wdata;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else     wcnt <= (ram_req && !ram_ack) ? wcnt + 1 : 0;
  end

  assign ram_ack   = ram_req && !ack_never && (wcnt >= ack_delay);
  assign ram_rdata = mem[ram_addr[15:3]];

  int errors = 0;
  int checks = 0;
  int valids = 0;
  int pushes = 0;
  logic [64:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic err, input logic [63:0] d);
    exp_q.push_back({err, d});
    pushes++;
  endtask

  // Refill scoreboard: every axi_r_valid must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst && axi_r_valid) begin
      logic [64:0] e;
      valids++;
      checks++;
      if (exp_q.size() == 0) begin
        assert (1'b0) else begin
          errors++;
          $error("FAIL unexpected_valid observed=%0h expected=none", {rd_err, rdata});
        end
      end else begin
        e = exp_q.pop_front();
        assert ({rd_err, rdata} === e) else begin
          errors++;
          $error("FAIL refill observed=%0h expected=%0h", {rd_err, rdata}, e);
        end
      end
    end
  end

  initial begin
    // Reset with RAM preload
    tick();
    pl_en = 1'b1; pl_idx = 13'h201; pl_dat = 64'hAA;
    tick();
    pl_idx = 13'h600; pl_dat = 64'h77;
    tick();
    pl_en = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ram_req", ram_req, 0);
    chk("rst_valid", axi_r_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_drop", req_drop, 0);
    rst = 1'b0;
    tick();

    // Read-only, immediate ack
    mem_r_ena = 1'b1; mem_raddr = 64'h1008; push(1'b0, 64'hAA);
    tick();
    mem_r_ena = 1'b0;
    chk("rd_ram_req", ram_req, 1);
    chk("rd_ram_we", ram_we, 0);
    chk("rd_ram_addr", ram_addr, 64'h1008);
    chk("rd_busy", busy, 1);
    tick();
    chk("rd_valid_c2", axi_r_valid, 1);
    tick();
    chk("rd_valid_c3", axi_r_valid, 0);
    chk("rd_busy_after", busy, 0);

    // Write + read in the same cycle
    mem_w_ena = 1'b1; mem_waddr = 64'h2000; mem_wdata = 64'h55;
    mem_r_ena = 1'b1; mem_raddr = 64'h3000; push(1'b0, 64'h77);
    tick();
    mem_w_ena = 1'b0; mem_r_ena = 1'b0;
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 64'h2000);
    chk("wr_ram_wdata", ram_wdata, 64'h55);
    tick();
    chk("wr_rd_ram_we", ram_we, 0);
    chk("wr_rd_ram_addr", ram_addr, 64'h3000);
    chk("wr_valid_c2", axi_r_valid, 0);
    tick();
    chk("wr_valid_c3", axi_r_valid, 1);
    tick();
    chk("wr_busy_after", busy, 0);

    // Unaligned read address is forced to the block boundary
    mem_r_ena = 1'b1; mem_raddr = 64'h2005; push(1'b0, 64'h55);
    tick();
    mem_r_ena = 1'b0;
    chk("align_ram_addr", ram_addr, 64'h2000);
    tick(); tick();

    // Write-back then refill of the same block
    mem_w_ena = 1'b1; mem_waddr = 64'h40; mem_wdata = 64'h1234;
    mem_r_ena = 1'b1; mem_raddr = 64'h40; push(1'b0, 64'h1234);
    tick();
    mem_w_ena = 1'b0; mem_r_ena = 1'b0;
    tick(); tick(); tick();
    chk("wbr_busy_after", busy, 0);

    // Delayed ack (5 cycles) with a dropped request in the middle
    ack_delay = 5;
    mem_r_ena = 1'b1; mem_raddr = 64'h1008; push(1'b0, 64'hAA);
    for (int i = 1; i <= 6; i++) begin
      tick();
      mem_r_ena = 1'b0;
      chk($sformatf("dly_req_c%0d", i), ram_req, 1);
      chk($sformatf("dly_addr_c%0d", i), ram_addr, 64'h1008);
      if (i == 2) begin
        mem_r_ena = 1'b1; mem_raddr = 64'h3000;
      end
      if (i == 3) chk("dly_drop_c3", req_drop, 1);
      if (i == 4) chk("dly_drop_c4", req_drop, 0);
    end
    tick();
    chk("dly_valid_c7", axi_r_valid, 1);
    chk("dly_ram_req_c7", ram_req, 0);
    tick();
    chk("dly_valid_c8", axi_r_valid, 0);
    chk("dly_busy_c8", busy, 0);
    ack_delay = 0;

    // Timeout (TIMEOUT=4, RAM never acks)
    mem_r_ena_t = 1'b1; mem_raddr = 64'h1008;
    for (int i = 1; i <= 4; i++) begin
      tick();
      mem_r_ena_t = 1'b0;
      chk($sformatf("tmo_req_c%0d", i), ram_req_t, 1);
      chk($sformatf("tmo_valid_c%0d", i), axi_r_valid_t, 0);
      if (i == 2) mem_r_ena_t = 1'b1;
      if (i == 3) chk("tmo_drop_c3", req_drop_t, 1);
    end
    tick();
    chk("tmo_valid", axi_r_valid_t, 1);
    chk("tmo_rd_err", rd_err_t, 1);
    chk("tmo_rdata", rdata_t, 0);
    chk("tmo_ram_req_off", ram_req_t, 0);
    tick();
    chk("tmo_valid_off", axi_r_valid_t, 0);
    chk("tmo_err_off", rd_err_t, 0);
    chk("tmo_busy_off", busy_t, 0);

    // Reset during a read wait
    ack_never = 1'b1;
    mem_r_ena = 1'b1; mem_raddr = 64'h3000;
    tick();
    mem_r_ena = 1'b0;
    tick(); tick();
    chk("mid_ram_req_pre", ram_req, 1);
    rst = 1'b1;
    #1;
    chk("mid_ram_req_rst", ram_req, 0);
    chk("mid_busy_rst", busy, 0);
    tick();
    rst = 1'b0;
    ack_never = 1'b0;
    repeat (20) tick();
    chk("mid_ram_req_after", ram_req, 0);
    chk("mid_busy_after", busy, 0);

    chk("sb_empty", exp_q.size(), 0);
    chk("valid_count", valids, pushes);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
